// File: rtl/window_fetch_seq.sv
// Window fetch stage: latches a window position, reads the 32 generated addresses in slot order, and assembles the returned words.
// Latency: done is RD_LAT+33 edges after the start-accept edge; no backpressure, start is ignored unless idle.
module window_fetch_seq #(
  parameter int          NUM_WORDS = 32,
  parameter int          DATA_W    = 32,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] MEM_BYTES = 32'd16384
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [31:0]                   win_pos,
  output logic [31:0]                   current_address,
  input  logic [32*NUM_WORDS-1:0]       addr_flat,
  output logic                          mem_rd_en,
  output logic [31:0]                   mem_addr,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [DATA_W*NUM_WORDS-1:0]   window_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int            IW       = $clog2(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] issue_idx;
  logic          accept, issue, drained;
  logic [31:0]   slot_addr;
  logic          slot_skip;

  // Capture pipeline: one stage per cycle of read latency.
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_skip;
  logic [IW-1:0]     pipe_idx [RD_LAT];

  assign slot_addr = addr_flat[32*issue_idx +: 32];
  assign slot_skip = (slot_addr >= MEM_BYTES);
  assign drained   = ~|pipe_vld;

  // Slot 0 issues on the SETTLE exit edge, so SETTLE and ISSUE both issue.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        issue     = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (issue_idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drained) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      current_address <= '0;
      issue_idx       <= '0;
      mem_rd_en       <= 1'b0;
      mem_addr        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        current_address <= win_pos;
        err             <= 1'b0;
        busy            <= 1'b1;
        issue_idx       <= '0;
      end
      if (issue) begin
        mem_rd_en <= ~slot_skip;
        mem_addr  <= slot_addr;
        issue_idx <= issue_idx + 1'b1;
        if (slot_skip) err <= 1'b1;
      end else begin
        mem_rd_en <= 1'b0;
      end
      if (state == DRAIN && drained) done <= 1'b1;
      if (state == DONE) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_skip <= '0;
      for (int j = 0; j < RD_LAT; j++) pipe_idx[j] <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_skip[0] <= issue & slot_skip;
      pipe_idx[0]  <= issue_idx;
      for (int j = 1; j < RD_LAT; j++) begin
        pipe_vld[j]  <= pipe_vld[j-1];
        pipe_skip[j] <= pipe_skip[j-1];
        pipe_idx[j]  <= pipe_idx[j-1];
      end
    end
  end

  // Skipped slots are written as zero so stale data never survives a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_data <= '0;
    end else if (pipe_vld[RD_LAT-1]) begin
      window_data[DATA_W*pipe_idx[RD_LAT-1] +: DATA_W] <=
        pipe_skip[RD_LAT-1] ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_window_fetch_seq.sv
// Directed bench for window_fetch_seq: two instances (RD_LAT=1 and RD_LAT=3) fed by a synthetic window generator and an address-echo memory.
module tb_window_fetch_seq;

  localparam int NW = 32;
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;
  // Word offset of each 4-slot row of the window, relative to win_pos.
  localparam logic [31:0] ROW_OFF [8] = '{32'd8, 32'd72, 32'd136, 32'd152,
                                          32'd168, 32'd184, 32'd196, 32'd204};

  logic clk, rst_n;
  logic start1, start3;
  logic [31:0] win_pos1, win_pos3;
  logic [31:0] cur1, cur3, mem_addr1, mem_addr3, mem_rdata1, mem_rdata3;
  logic [32*NW-1:0] af1, af3, wd1, wd3;
  logic mem_rd_en1, mem_rd_en3, busy1, busy3, done1, done3, err1, err3;

  int checks = 0;
  int errors = 0;
  logic [31:0] addr_log [NW];
  logic        en_log   [NW];
  int edges;
  int bad;

  function automatic logic [31:0] exp_addr(input logic [31:0] pos, input int k);
    return (pos + ROW_OFF[k/4] + 32'(k % 4)) << 2;
  endfunction

  function automatic logic [32*NW-1:0] gen(input logic [31:0] pos);
    logic [32*NW-1:0] g;
    g = '0;
    for (int k = 0; k < NW; k++) g[32*k +: 32] = exp_addr(pos, k);
    return g;
  endfunction

  function automatic logic [31:0] slot(input logic [32*NW-1:0] w, input int k);
    return w[32*k +: 32];
  endfunction

  assign af1 = gen(cur1);
  assign af3 = gen(cur3);

  // Memory returns the byte address as data; unrequested cycles return junk.
  assign mem_rdata1 = mem_rd_en1 ? mem_addr1 : BAD_DATA;

  logic        m3_v [2];
  logic [31:0] m3_a [2];
  always @(posedge clk) begin
    m3_v[0] <= mem_rd_en3;
    m3_a[0] <= mem_addr3;
    m3_v[1] <= m3_v[0];
    m3_a[1] <= m3_a[0];
  end
  assign mem_rdata3 = m3_v[1] ? m3_a[1] : BAD_DATA;

  window_fetch_seq #(.NUM_WORDS(NW), .DATA_W(32), .RD_LAT(1), .MEM_BYTES(32'd16384)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .win_pos(win_pos1),
    .current_address(cur1), .addr_flat(af1), .mem_rd_en(mem_rd_en1),
    .mem_addr(mem_addr1), .mem_rdata(mem_rdata1), .window_data(wd1),
    .busy(busy1), .done(done1), .err(err1));

  window_fetch_seq #(.NUM_WORDS(NW), .DATA_W(32), .RD_LAT(3), .MEM_BYTES(32'd16384)) d3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .win_pos(win_pos3),
    .current_address(cur3), .addr_flat(af3), .mem_rd_en(mem_rd_en3),
    .mem_addr(mem_addr3), .mem_rdata(mem_rdata3), .window_data(wd3),
    .busy(busy3), .done(done3), .err(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after the start-accept edge's negedge; counts edges until done.
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    while (!(sel ? done3 : done1) && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n >= 1 && n <= NW) begin
        addr_log[n-1] = sel ? mem_addr3 : mem_addr1;
        en_log[n-1]   = sel ? mem_rd_en3 : mem_rd_en1;
      end
    end
  endtask

  task automatic fetch(input bit sel, input logic [31:0] pos, output int n);
    @(negedge clk);
    if (sel) begin win_pos3 = pos; start3 = 1'b1; end
    else begin win_pos1 = pos; start1 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    wait_done(sel, n);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; win_pos1 = '0; win_pos3 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en1), 32'd0);
    check("rst_cur", cur1, 32'd0);
    check("rst_wd_zero", 32'(|wd1), 32'd0);
    rst_n = 1'b1;

    // In-range fetch at win_pos 0.
    fetch(1'b0, 32'd0, edges);
    check("lat1_edges", 32'(edges), 32'd34);
    check("seq_a0", addr_log[0], 32'd32);
    check("seq_a1", addr_log[1], 32'd36);
    check("seq_a3", addr_log[3], 32'd44);
    check("seq_a4", addr_log[4], 32'd288);
    check("seq_a31", addr_log[31], 32'd828);
    check("seq_en31", 32'(en_log[31]), 32'd1);
    check("slot0", slot(wd1, 0), 32'd32);
    check("slot4", slot(wd1, 4), 32'd288);
    check("slot31", slot(wd1, 31), 32'd828);
    check("err_inrange", 32'(err1), 32'd0);
    check("busy_at_done", 32'(busy1), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(done1), 32'd0);
    check("busy_fall", 32'(busy1), 32'd0);

    // Window crossing the top of memory: last two slots out of range.
    fetch(1'b0, 32'd3890, edges);
    check("oor_edges", 32'(edges), 32'd34);
    check("oor_en29", 32'(en_log[29]), 32'd1);
    check("oor_en30", 32'(en_log[30]), 32'd0);
    check("oor_en31", 32'(en_log[31]), 32'd0);
    check("oor_a30", addr_log[30], 32'd16384);
    check("oor_slot29", slot(wd1, 29), 32'd16380);
    check("oor_slot30", slot(wd1, 30), 32'd0);
    check("oor_slot31", slot(wd1, 31), 32'd0);
    check("oor_err", 32'(err1), 32'd1);
    @(negedge clk);
    check("err_held", 32'(err1), 32'd1);

    // start held through a whole fetch; win_pos changes mid-fetch.
    @(negedge clk);
    win_pos1 = 32'd5; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    win_pos1 = 32'd100;
    wait_done(1'b0, edges);
    check("held_edges", 32'(edges), 32'd34);
    check("held_cur", cur1, 32'd5);
    check("held_slot0", slot(wd1, 0), 32'd52);
    @(negedge clk);
    check("held_idle_busy", 32'(busy1), 32'd0);
    check("held_idle_cur", cur1, 32'd5);
    @(negedge clk);
    check("held_reaccept_busy", 32'(busy1), 32'd1);
    check("held_reaccept_cur", cur1, 32'd100);
    check("held_err_clear", 32'(err1), 32'd0);
    start1 = 1'b0;
    wait_done(1'b0, edges);
    check("second_edges", 32'(edges), 32'd34);
    check("second_slot0", slot(wd1, 0), 32'd432);
    @(negedge clk);

    // Reset while slot 10 is being issued.
    @(negedge clk);
    win_pos1 = 32'd0; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    edges = 0;
    while (edges < 11) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("pre_rst_rd_en", 32'(mem_rd_en1), 32'd1);
    check("pre_rst_addr", mem_addr1, 32'd552);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", 32'(mem_rd_en1), 32'd0);
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_wd_zero", 32'(|wd1), 32'd0);
    check("mid_rst_cur", cur1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch(1'b0, 32'd0, edges);
    check("post_rst_edges", 32'(edges), 32'd34);
    check("post_rst_slot31", slot(wd1, 31), 32'd828);
    check("post_rst_slot10", slot(wd1, 10), 32'd552);
    @(negedge clk);

    // Three-cycle read latency.
    fetch(1'b1, 32'd1, edges);
    check("lat3_edges", 32'(edges), 32'd36);
    check("lat3_slot0", slot(wd3, 0), 32'd36);
    check("lat3_slot31", slot(wd3, 31), 32'd832);
    bad = 0;
    for (int k = 0; k < NW; k++) if (slot(wd3, k) !== exp_addr(32'd1, k)) bad++;
    check("lat3_all_slots_bad", 32'(bad), 32'd0);
    check("lat3_err", 32'(err3), 32'd0);
    @(negedge clk);
    check("lat3_busy_fall", 32'(busy3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
